acc_unit: RTL and testbench

ACC_UNIT -- requirements
Module: acc_unit

---
 rtl/acc_unit.sv | 111 +++++++++++
 tb/tb_acc_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_unit.sv
// acc_unit: accumulates a start-specified number of unsigned operands into an
// N-bit sum with a sticky carry-out flag, then offers the result with a
// valid/ready handshake.
// Optional macro ACC_SATURATE_EN: a carry clamps the sum to all ones instead
// of letting it wrap.
module acc_unit #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_ops,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  Din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  Acc,
  output logic          Ovf
);

  localparam int unsigned SW = N + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] sum_c;
  logic          accept_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Acc       = acc_q;
  assign Ovf       = ovf_q;

  // Next-state, datapath and handshake flags computed from current state.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    accept_c    = in_valid && in_ready_q;
    sum_c       = SW'({1'b0, acc_q}) + SW'({1'b0, Din});

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = (num_ops == '0) ? CW'(1) : num_ops;
        end
      end
      S_ACCUM: begin
        if (accept_c) begin
`ifdef ACC_SATURATE_EN
          acc_d = sum_c[N] ? {N{1'b1}} : sum_c[N-1:0];
`else
          acc_d = sum_c[N-1:0];
`endif
          ovf_d = ovf_q | sum_c[N];
          // Count never goes below zero; zero or one both mean last operand.
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_ACCUM);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: stimulus pushes expected results into a
// queue, a monitor compares them whenever the DUT presents a result.
module tb_acc_unit;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_ops;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  Din;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  Acc;
  logic          Ovf;

  typedef struct {
    logic [N-1:0] acc;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  acc_unit #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_ops  (num_ops),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Din      (Din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Acc      (Acc),
    .Ovf      (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare every presented result to the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got Acc=%0d Ovf=%0d expected none", Acc, Ovf);
      end else begin
        check("result_acc", int'(Acc), int'(exp_q[0].acc));
        check("result_ovf", int'(Ovf), int'(exp_q[0].ovf));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input logic [CW-1:0] n);
    start   = 1'b1;
    num_ops = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_op(input logic [N-1:0] v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    Din      = v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  function automatic exp_t mk(input int a, input int o);
    exp_t e;
    e.acc = N'(a);
    e.ovf = o[0];
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_ops   = '0;
    in_valid  = 1'b0;
    Din       = '0;
    out_ready = 1'b1;

    #12;
    check("reset_acc",       int'(Acc), 0);
    check("reset_ovf",       int'(Ovf), 0);
    check("reset_in_ready",  int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", int'(in_ready), 0);

    // Basic sum 15+1+10, back-to-back.
    exp_q.push_back(mk(26, 0));
    do_start(4'd3);
    send_op(8'd15); send_op(8'd1); send_op(8'd10);
    @(negedge clk);
    check("basic_latency", int'(out_valid), 1);
    @(posedge clk); #1;

    // Overflow 255+1.
`ifdef ACC_SATURATE_EN
    exp_q.push_back(mk(255, 1));
`else
    exp_q.push_back(mk(0, 1));
`endif
    do_start(4'd2);
    send_op(8'd255); send_op(8'd1);
    @(posedge clk); #1;

    // Bubbles between operands and result backpressure.
    exp_q.push_back(mk(255, 0));
    out_ready = 1'b0;
    do_start(4'd2);
    send_op(8'd170);
    repeat (3) @(posedge clk);
    #1 send_op(8'd85);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_out_valid", int'(out_valid), 0);
    check("bp_idle_in_ready",  int'(in_ready), 0);
    check("bp_acc_retained",   int'(Acc), 255);

    // num_ops=0 behaves as one operand.
    exp_q.push_back(mk(7, 0));
    do_start(4'd0);
    send_op(8'd7);
    @(negedge clk);
    check("zero_ops_latency", int'(out_valid), 1);
    @(posedge clk); #1;

    // Start pulses in ACCUM and DONE are ignored.
    exp_q.push_back(mk(7, 0));
    out_ready = 1'b0;
    do_start(4'd2);
    send_op(8'd3);
    do_start(4'd5);
    send_op(8'd4);
    @(negedge clk);
    check("ign_start_done", int'(out_valid), 1);
    @(posedge clk); #1 do_start(4'd5);
    @(negedge clk);
    check("ign_start_still_done", int'(out_valid), 1);
    check("ign_start_no_ready",   int'(in_ready), 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    do_start(4'd3);
    @(negedge clk);
    check("hs_start_out_valid", int'(out_valid), 0);
    check("hs_start_in_ready",  int'(in_ready), 0);
    @(negedge clk);
    check("hs_start_stay_idle", int'(in_ready), 0);

    // Reset mid-ACCUM after two operands, no clock edge needed.
    do_start(4'd4);
    send_op(8'd1); send_op(8'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_acc",       int'(Acc), 0);
    check("mid_rst_ovf",       int'(Ovf), 0);
    check("mid_rst_in_ready",  int'(in_ready), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid = 1'b1; Din = 8'd9;
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'(in_ready), 0);
    check("post_rst_acc",  int'(Acc), 0);
    @(posedge clk); #1 in_valid = 1'b0;

    // Maximum count: fifteen operands of 20 (300).
`ifdef ACC_SATURATE_EN
    exp_q.push_back(mk(255, 1));
`else
    exp_q.push_back(mk(44, 1));
`endif
    do_start(4'd15);
    for (int k = 0; k < 15; k++) send_op(8'd20);
    @(negedge clk);
    check("max_ops_latency", int'(out_valid), 1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
